// File: rtl/mem_axi_arbiter_pkg.sv
// Shared types for the fetch/mem AXI4-Lite bus back-end.
// Request bundle, arbiter state encoding and AXI response codes.
package mem_axi_arbiter_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_RESP
    } arb_state_e;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_req_latch.sv
// Per-client holding register: captures one request and keeps it
// pending until the arbiter pulses the response back to the client.
module mem_req_latch
    import mem_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        mode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        clear_i,
    output logic        pend_o,
    output mem_req_t    req_o
);

    logic     pend_q, pend_d;
    mem_req_t req_q, req_d;
    logic     accept;

    // A strobe in the response cycle is taken as the next request.
    assign accept = req_i && (!pend_q || clear_i);

    always_comb begin
        pend_d = pend_q;
        req_d  = req_q;
        if (accept) begin
            pend_d      = 1'b1;
            req_d.mode  = mode_i;
            req_d.addr  = addr_i;
            req_d.wdata = wdata_i;
            req_d.wstrb = wstrb_i;
        end else if (clear_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q <= 1'b0;
            req_q  <= '0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
        end
    end

    assign pend_o = pend_q;
    assign req_o  = req_q;

endmodule

// File: rtl/mem_axi_arbiter.sv
// Arbitrates fetch and mem requests (mem first) and runs each one
// as a single AXI4-Lite read or write transaction.
module mem_axi_arbiter
    import mem_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        f_request_enable,
    input  logic        m_request_enable,
    input  logic        f_mode,
    input  logic        m_mode,
    input  logic [31:0] f_addr,
    input  logic [31:0] m_addr,
    input  logic [31:0] f_wdata,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  f_wstrb,
    input  logic [3:0]  m_wstrb,
    output logic        f_response_enable,
    output logic        m_response_enable,
    output logic [31:0] f_data,
    output logic [31:0] m_data,
    output logic        bus_error,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [2:0]  axi_arprot,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [2:0]  axi_awprot,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        err_q, err_d;
    logic [31:0] f_data_q, f_data_d;
    logic [31:0] m_data_q, m_data_d;

    logic        f_pend, m_pend;
    logic        f_clear, m_clear;
    mem_req_t    f_req, m_req, cur;

    assign f_clear = (state_q == ST_RESP) && !owner_q;
    assign m_clear = (state_q == ST_RESP) && owner_q;

    mem_req_latch u_f_latch (
        .clk     (clk),
        .rstn    (rstn),
        .req_i   (f_request_enable),
        .mode_i  (f_mode),
        .addr_i  (f_addr),
        .wdata_i (f_wdata),
        .wstrb_i (f_wstrb),
        .clear_i (f_clear),
        .pend_o  (f_pend),
        .req_o   (f_req)
    );

    mem_req_latch u_m_latch (
        .clk     (clk),
        .rstn    (rstn),
        .req_i   (m_request_enable),
        .mode_i  (m_mode),
        .addr_i  (m_addr),
        .wdata_i (m_wdata),
        .wstrb_i (m_wstrb),
        .clear_i (m_clear),
        .pend_o  (m_pend),
        .req_o   (m_req)
    );

    // owner_q: 1 = mem, 0 = fetch
    assign cur = owner_q ? m_req : f_req;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        f_data_d  = f_data_q;
        m_data_d  = m_data_q;
        unique case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (m_pend) begin
                    owner_d = 1'b1;
                    state_d = (m_req.mode == MEMREQ_WRITE) ? ST_AW_W : ST_AR;
                end else if (f_pend) begin
                    owner_d = 1'b0;
                    state_d = (f_req.mode == MEMREQ_WRITE) ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (axi_arready) state_d = ST_AR == ST_AR ? ST_R : ST_AR;
            end
            ST_R: begin
                if (axi_rvalid) begin
                    err_d = (axi_rresp != AXI_RESP_OKAY);
                    if (owner_q) m_data_d = axi_rdata;
                    else         f_data_d = axi_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q | axi_awready;
                w_done_d  = w_done_q | axi_wready;
                if (aw_done_d && w_done_d) state_d = ST_B;
            end
            ST_B: begin
                if (axi_bvalid) begin
                    err_d = (axi_bresp != AXI_RESP_OKAY);
                    if (owner_q) m_data_d = 32'h0;
                    else         f_data_d = 32'h0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            f_data_q  <= 32'h0;
            m_data_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            f_data_q  <= f_data_d;
            m_data_q  <= m_data_d;
        end
    end

    assign axi_arvalid = (state_q == ST_AR);
    assign axi_rready  = (state_q == ST_R);
    assign axi_awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign axi_wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign axi_bready  = (state_q == ST_B);

    assign axi_araddr = cur.addr;
    assign axi_awaddr = cur.addr;
    assign axi_wdata  = cur.wdata;
    assign axi_wstrb  = cur.wstrb;
    assign axi_arprot = 3'b000;
    assign axi_awprot = 3'b000;

    assign f_response_enable = f_clear;
    assign m_response_enable = m_clear;
    assign bus_error         = (state_q == ST_RESP) && err_q;
    assign f_data            = f_data_q;
    assign m_data            = m_data_q;

endmodule
